// File: rtl/cpu_run_ctrl_pkg.sv
// ============================================================================
// Module  : run_ctrl_pkg
// Brief   : Shared state encoding and command opcodes for cpu_run_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_HALTED   = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_STEPPING = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_HALT  = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter with enable and synchronous clear; sticks at all-ones.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// Module  : cpu_run_ctrl
// Brief   : Core reset stretcher and clock-enable run control (run/halt/
//           step/soft reset). Optional PC breakpoint under RUN_CTRL_BP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 4,
  parameter int CNT_W    = 16,
  parameter int PC_W     = 32,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [PC_W-1:0]  cpu_pc,
  output logic             cpu_rst_n,
  output logic             cpu_ce,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef RUN_CTRL_BP_EN
  ,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_en,
  output logic             bp_hit
`endif
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(RST_HOLD - 1);

  state_t             r_state, w_state_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
  logic [CNT_W-1:0]   r_step_rem, w_step_nxt;
  logic               r_cpu_rst_n;
  logic               w_run_state, w_bp_mask, w_cpu_ce;
  logic               w_cmd_fire, w_clr_cnt, w_resume;

  assign w_run_state = (r_state == ST_RUNNING) || (r_state == ST_STEPPING);
  assign w_cpu_ce    = w_run_state && !w_bp_mask;
  assign w_cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_step_nxt  = r_step_rem;
    w_clr_cnt   = 1'b0;
    w_resume    = 1'b0;
    unique case (r_state)
      ST_RST_HOLD: begin
        if (r_hold_cnt == c_hold_last) begin
          w_state_nxt = AUTO_RUN ? ST_RUNNING : ST_HALTED;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_STEPPING: begin
        if (w_cpu_ce) begin
          w_step_nxt = r_step_rem - 1'b1;
          if (r_step_rem == CNT_W'(1)) w_state_nxt = ST_HALTED;
        end
      end
      default: ;
    endcase

    if (w_bp_mask) w_state_nxt = ST_HALTED;

    // An accepted command overrides step completion and breakpoint stops.
    if (w_cmd_fire) begin
      case (cmd_op)
        OP_RUN: begin
          w_state_nxt = ST_RUNNING;
          w_resume    = 1'b1;
        end
        OP_HALT: w_state_nxt = ST_HALTED;
        OP_STEP: begin
          w_resume = 1'b1;
          if (cmd_cnt != '0) begin
            w_state_nxt = ST_STEPPING;
            w_step_nxt  = cmd_cnt;
          end else begin
            w_state_nxt = ST_HALTED;
          end
        end
        default: begin
          w_state_nxt = ST_RST_HOLD;
          w_hold_nxt  = '0;
          w_clr_cnt   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RST_HOLD;
      r_hold_cnt  <= '0;
      r_step_rem  <= '0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_step_rem  <= w_step_nxt;
      r_cpu_rst_n <= (w_state_nxt != ST_RST_HOLD);
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_cpu_ce),
    .clr   (w_clr_cnt),
    .count (cycle_cnt)
  );

`ifdef RUN_CTRL_BP_EN
  logic r_resume_skip;
  logic r_bp_hit;

  // Skip the compare on the first cycle after resuming so the core can leave bp_addr.
  assign w_bp_mask = bp_en && (cpu_pc == bp_addr) && w_run_state && !r_resume_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resume_skip <= 1'b0;
      r_bp_hit      <= 1'b0;
    end else begin
      r_resume_skip <= w_resume;
      if (w_clr_cnt || w_resume) begin
        r_bp_hit <= 1'b0;
      end else if (w_bp_mask) begin
        r_bp_hit <= 1'b1;
      end
    end
  end

  assign bp_hit = r_bp_hit;
`else
  logic w_unused_bp;
  assign w_bp_mask   = 1'b0;
  assign w_unused_bp = ^{cpu_pc, w_resume};
`endif

  assign cpu_ce    = w_cpu_ce;
  assign cpu_rst_n = r_cpu_rst_n;
  assign halted    = (r_state == ST_HALTED);
  assign cmd_ready = (r_state != ST_RST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// Module  : tb_cpu_run_ctrl
// Brief   : Scoreboard bench for cpu_run_ctrl: default, AUTO_RUN=0 and CNT_W=4
//           instances; breakpoint scenario when RUN_CTRL_BP_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;
  import run_ctrl_pkg::*;

  typedef struct {
    int    cyc;
    int    dut;
    string name;
    logic  rstn;
    logic  ce;
    logic  hlt;
    logic  rdy;
    logic  bp;
    int    cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v0, v1, v2;
  logic [1:0]  op0, op1, op2;
  logic [15:0] n0, n1;
  logic [3:0]  n2;
  logic        rdy0, rdy1, rdy2, ce0, ce1, ce2, rstn0, rstn1, rstn2, h0, h1, h2;
  logic [15:0] cc0, cc1;
  logic [3:0]  cc2;
  logic [31:0] pc0;
  logic        bph0;

  always @(posedge clk) begin
    if (!rstn0)   pc0 <= 32'h0;
    else if (ce0) pc0 <= pc0 + 32'd4;
  end

`ifdef RUN_CTRL_BP_EN
  logic        bp_en0;
  logic [31:0] bp_addr0;
  logic        bph1, bph2;
`else
  assign bph0 = 1'b0;
`endif

  cpu_run_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_op(op0),
    .cmd_cnt(n0), .cpu_pc(pc0), .cpu_rst_n(rstn0), .cpu_ce(ce0), .halted(h0),
    .cycle_cnt(cc0)
`ifdef RUN_CTRL_BP_EN
    , .bp_addr(bp_addr0), .bp_en(bp_en0), .bp_hit(bph0)
`endif
  );

  cpu_run_ctrl #(.AUTO_RUN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(op1),
    .cmd_cnt(n1), .cpu_pc(32'h0), .cpu_rst_n(rstn1), .cpu_ce(ce1), .halted(h1),
    .cycle_cnt(cc1)
`ifdef RUN_CTRL_BP_EN
    , .bp_addr(32'h0), .bp_en(1'b0), .bp_hit(bph1)
`endif
  );

  cpu_run_ctrl #(.CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_op(op2),
    .cmd_cnt(n2), .cpu_pc(32'h0), .cpu_rst_n(rstn2), .cpu_ce(ce2), .halted(h2),
    .cycle_cnt(cc2)
`ifdef RUN_CTRL_BP_EN
    , .bp_addr(32'h0), .bp_en(1'b0), .bp_hit(bph2)
`endif
  );

  function automatic logic [20:0] obs(input int d);
    case (d)
      0:       return {rstn0, ce0, h0, rdy0, bph0, cc0};
      1:       return {rstn1, ce1, h1, rdy1, 1'b0, cc1};
      default: return {rstn2, ce2, h2, rdy2, 1'b0, 12'd0, cc2};
    endcase
  endfunction

  task automatic push_exp(input int d, input int k, input string nm, input logic rstn,
                          input logic ce, input logic hlt, input logic rdy, input int cnt,
                          input logic bp = 1'b0);
    exp_t e;
    e.cyc = cyc + k; e.dut = d; e.name = nm;
    e.rstn = rstn; e.ce = ce; e.hlt = hlt; e.rdy = rdy; e.bp = bp; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input logic ok);
    n_total++;
    if (ok === 1'b1) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc%0d", nm, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every sampled cycle is a DUT output beat; compare all entries due now.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        exp_t        e;
        logic [20:0] got, want;
        e    = sb[i];
        sb.delete(i);
        got  = obs(e.dut);
        want = {e.rstn, e.ce, e.hlt, e.rdy, e.bp, 16'(e.cnt)};
        n_total++;
        if (e.cyc == cyc && got === want) begin
          n_pass++;
        end else begin
          $display("FAIL %s dut%0d cyc%0d: got rstn/ce/halt/rdy/bp=%b cnt=%0d, want %b cnt=%0d",
                   e.name, e.dut, cyc, got[20:16], got[15:0], want[20:16], want[15:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    op0 = OP_RUN; op1 = OP_RUN; op2 = OP_RUN;
    n0 = '0; n1 = '0; n2 = '0;
`ifdef RUN_CTRL_BP_EN
    bp_en0   = 1'b0;
    bp_addr0 = 32'h0000_0010;
`endif
    repeat (2) tick();
    for (int d = 0; d < 3; d++) check($sformatf("reset_state_dut%0d", d), obs(d) === 21'd0);
    for (int d = 0; d < 3; d++) push_exp(d, 0, "in_reset", 0, 0, 0, 0, 0);
    tick();

    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) push_exp(d, 3, "hold", 0, 0, 0, 0, 0);
    push_exp(0, 4, "release", 1, 1, 0, 1, 0);
    push_exp(0, 5, "count1", 1, 1, 0, 1, 1);
    push_exp(1, 4, "autorun0_halted", 1, 0, 1, 1, 0);
    push_exp(2, 4, "sat_release", 1, 1, 0, 1, 0);
    push_exp(2, 18, "sat_14", 1, 1, 0, 1, 14);
    push_exp(2, 19, "sat_15", 1, 1, 0, 1, 15);
    push_exp(2, 25, "sat_hold", 1, 1, 0, 1, 15);
    repeat (6) tick();

    push_exp(0, 0, "halt_accept_cycle", 1, 1, 0, 1, 2);
    v0 = 1'b1; op0 = OP_HALT;
    v1 = 1'b1; op1 = OP_STEP; n1 = 16'd3;
    tick();
    v1 = 1'b0;
    op0 = OP_STEP; n0 = 16'd0;
    push_exp(0, 0, "halt_done", 1, 0, 1, 1, 3);
    push_exp(0, 1, "step0_noop", 1, 0, 1, 1, 3);
    push_exp(1, 0, "step3_first", 1, 1, 0, 1, 0);
    push_exp(1, 2, "step3_third", 1, 1, 0, 1, 2);
    push_exp(1, 3, "step3_done", 1, 0, 1, 1, 3);
    push_exp(1, 6, "step3_stays", 1, 0, 1, 1, 3);
    tick();
    op0 = OP_RUN;
    tick();
    op0 = OP_STEP; n0 = 16'd7;
    tick();
    v0 = 1'b0;
    push_exp(0, 0, "step7_start", 1, 1, 0, 1, 4);
    repeat (2) tick();

    v0 = 1'b1; op0 = OP_RESET;
    tick();
    op0 = OP_HALT;
`ifdef RUN_CTRL_BP_EN
    bp_en0 = 1'b1;
`endif
    push_exp(0, 0, "reset_cmd", 0, 0, 0, 0, 0);
    push_exp(0, 3, "reset_hold", 0, 0, 0, 0, 0);
    push_exp(0, 4, "reset_exit", 1, 1, 0, 1, 0);
    push_exp(0, 6, "rerun_count", 1, 1, 0, 1, 2);
    repeat (3) tick();
    v0 = 1'b0;
    tick();

`ifdef RUN_CTRL_BP_EN
    push_exp(0, 4, "bp_stop", 1, 0, 0, 1, 4, 1'b0);
    push_exp(0, 5, "bp_halted", 1, 0, 1, 1, 4, 1'b1);
    repeat (5) tick();
    v0 = 1'b1; op0 = OP_RUN;
    tick();
    v0 = 1'b0;
    push_exp(0, 0, "bp_resume", 1, 1, 0, 1, 4, 1'b0);
    push_exp(0, 1, "bp_run_on", 1, 1, 0, 1, 5, 1'b0);
`endif
    repeat (12) tick();

    check("scoreboard_drained", sb.size() == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run-control block between the board/bench clock-reset source and the single-cycle MIPS core. It produces the core's reset (stretched, synchronously deasserted) and a per-cycle clock enable. It supports free run, halt, N-cycle step and soft reset through a valid/ready command port, and keeps an executed-cycle counter. It is the parametrised successor to a fixed "release reset, then run forever" stimulus.

Parameters:
RST_HOLD, 4, cycles cpu_rst_n is held low after reset release or a RESET command (≥1)
CNT_W, 16, width of step count and cycle counter
PC_W, 32, width of the core PC
AUTO_RUN, 1, 1: enter RUNNING after reset hold; 0: enter HALTED

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when valid&&ready at a rising edge
cmd_op  in  2  0=RUN, 1=HALT, 2=STEP, 3=RESET
cmd_cnt  in  CNT_W  step count for STEP
cpu_pc  in  PC_W  current core PC (address of the instruction that executes on the next enabled edge)
cpu_rst_n  out  1  core reset, active-low
cpu_ce  out  1  core clock enable
halted  out  1  state==HALTED
cycle_cnt  out  CNT_W  number of cycles with cpu_ce=1 since the last reset
bp_addr  in  PC_W  breakpoint address (RUN_CTRL_BP_EN only)
bp_en  in  1  breakpoint enable (RUN_CTRL_BP_EN only)
bp_hit  out  1  sticky breakpoint flag (RUN_CTRL_BP_EN only)

Behaviour:
- Async reset (rst_n=0): state=RST_HOLD, hold counter=0, cpu_rst_n=0, cpu_ce=0, cmd_ready=0, halted=0, cycle_cnt=0, step remaining=0, bp_hit=0.
- cpu_rst_n is registered. It is driven low in RST_HOLD and rises on the edge that leaves RST_HOLD, so deassertion is always synchronous to clk.
- RST_HOLD: count RST_HOLD cycles, then go to RUNNING (AUTO_RUN=1) or HALTED (AUTO_RUN=0). cmd_ready=0; commands are ignored.
- cmd_ready=1 in every other state. Commands are sampled on the edge where valid&&ready. The new state takes effect from the next cycle.
- cpu_ce is combinational: 1 when state ∈ {RUNNING, STEPPING} and no breakpoint mask is active. It is 0 in RST_HOLD and HALTED.
- HALTED: RUN→RUNNING. STEP with cnt≠0→STEPPING, remaining=cmd_cnt. STEP with cnt=0 is accepted as a no-op. HALT is a no-op. RESET→RST_HOLD.
- RUNNING: HALT→HALTED. The acceptance cycle still has cpu_ce=1, so exactly one more instruction executes. RUN is a no-op. STEP→STEPPING with remaining=cmd_cnt (cnt=0 behaves as HALT). RESET→RST_HOLD.
- STEPPING: remaining decrements on each cpu_ce cycle. When cpu_ce=1 and remaining=1, go to HALTED next. A STEP of N gives exactly N cpu_ce cycles. HALT, RUN and RESET are handled as in RUNNING.
- RESET command: cycle_cnt=0, bp_hit=0, then RST_HOLD for RST_HOLD cycles. If rst_n is asserted mid-operation, everything returns to the reset values immediately.
- cycle_cnt increments on each cpu_ce=1 cycle and saturates at 2^CNT_W−1 (no wrap).

Optional Feature:
RUN_CTRL_BP_EN
- Defined:
  - If bp_en and cpu_pc==bp_addr and state ∈ {RUNNING, STEPPING}, and the cycle is not the first cycle after a RUN/STEP acceptance (resume-skip flag), then cpu_ce=0 that cycle, the next state is HALTED and bp_hit is set.
  - The instruction at bp_addr is therefore not executed until the next RUN or STEP.
  - bp_hit is cleared by acceptance of RUN or STEP.
- Undefined: the bp_addr, bp_en and bp_hit ports are absent and cpu_ce never masks.

Decomposition:
- Shared package run_ctrl_pkg holds:
  - the state enum: RST_HOLD, HALTED, RUNNING, STEPPING;
  - the cmd_op constants: OP_RUN, OP_HALT, OP_STEP, OP_RESET.
- One natural sub-module, sat_counter (parametrised width, enable, clear, saturate), used for cycle_cnt.
- The step and hold counters stay inline.

Test Plan:
- Reset release, defaults (RST_HOLD=4, AUTO_RUN=1): rst_n rises → cpu_rst_n rises on the 4th edge, cpu_ce=1 the following cycle, cycle_cnt counts 1, 2, 3…
- AUTO_RUN=0: after hold, halted=1 and cpu_ce=0. STEP cnt=3 → exactly 3 cpu_ce cycles, then halted=1 and cycle_cnt=3.
- Running, HALT accepted → one further cpu_ce cycle, then halted=1. STEP cnt=0 while halted → state unchanged, cmd_ready stays 1.
- RESET command while STEPPING with remaining=5 → cpu_rst_n=0 for 4 cycles, cycle_cnt=0, cmd_ready=0 during hold. A cmd_valid asserted during the hold is ignored.
- CNT_W=4, continuous run → cycle_cnt reaches 15 and holds at 15.
- RUN_CTRL_BP_EN, bp_addr=0x0000_0010, bp_en=1: PC reaches 0x10 → cpu_ce=0 that cycle, halted=1, bp_hit=1. RUN → bp_hit clears, the 0x10 instruction executes (cpu_ce=1), and running continues.
